dcim_shift_accumulator: RTL and testbench
=========================================

# dcim_shift_accumulator

Bit-serial shift-accumulate stage sitting directly downstream of a column of `oai_mult` bit multipliers in the DCIM macro. Each cycle it accepts one activation bit-plane's worth of 12-bit OAI results, one per row. It reduces them with an adder tree and folds the sum into a running accumulator, MSB plane first. After `IN_BITS` planes it presents one column dot-product result through a valid/ready handshake.

## Interface

Parameters:

- `NUM_ROWS`, 8: OAI multipliers per column; power of two, ≥2.
- `PP_W`, 12: width of each OAI result.
- `IN_BITS`, 8: activation bit-planes per operation; ≥2.
- `SUM_W`, `PP_W+$clog2(NUM_ROWS)` (15): adder-tree output width.
- `ACC_W`, `SUM_W+IN_BITS+1` (24): accumulator and result width.

Ports:

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pp_valid`, in, 1: a bit-plane of partial products is present.
- `pp_ready`, out, 1: the block accepts a plane this cycle.
- `pp_data`, in, `NUM_ROWS*PP_W`: row r occupies bits `[r*PP_W +: PP_W]`, unsigned.
- `res_valid`, out, 1: `res_data` holds a completed result.
- `res_ready`, in, 1: the consumer accepts the result.
- `res_data`, out, `ACC_W`: two's-complement dot product.
- `busy`, out, 1: high in ACCUM or DONE.

## Operation

- A plane transfers when `pp_valid && pp_ready`. A result transfers when `res_valid && res_ready`.
- FSM states:
  - IDLE: `pp_ready=1`. A transfer loads `acc <= sum` (or `-sum`, see Configuration), sets `cnt <= 1`, and moves to ACCUM.
  - ACCUM: `pp_ready=1`. Each transfer does `acc <= (acc<<1) + sum` and `cnt <= cnt+1`. The transfer with `cnt == IN_BITS-1` moves to DONE.
  - DONE: `pp_ready=0`, `res_valid=1`, `res_data=acc`. A result transfer returns to IDLE.
- `sum` is the combinational unsigned sum of all `NUM_ROWS` partial products, zero-extended to `SUM_W`. It cannot overflow.
- Accumulation is performed in `ACC_W` two's complement. With the default widths it cannot overflow for any input.
- Cycles with `pp_valid=0` are bubbles. They leave `acc` and `cnt` unchanged, and the block has no timeout.
- `pp_data` is ignored when no transfer occurs.
- `res_data` is stable for as long as `res_valid=1`.
- `cnt` is `$clog2(IN_BITS+1)` bits wide and resets to 0 in IDLE.

## Timing

- Reset values: state IDLE, `acc=0`, `cnt=0`, `pp_ready=1`, `res_valid=0`, `res_data=0`, `busy=0`.
- Reset applied mid-operation (ACCUM or DONE) discards the partial or pending result. The next cycle is IDLE with all reset values.
- Latency: `res_valid` rises in the cycle after the final plane transfer.
- Throughput: at most one operation per `IN_BITS+1` cycles, because DONE always costs at least one cycle.
- No combinational path runs from `res_ready` to `pp_ready`. `pp_ready` depends on state only.

## Configuration

- `DCIM_SIGNED_ACT_EN` defined: activations are two's complement.
  - The first (MSB) plane loads `acc <= -sum`. All later planes add as normal.
  - The result is signed.
- `DCIM_SIGNED_ACT_EN` not defined: activations are unsigned.
  - The MSB plane loads `acc <= sum`.
  - `res_data[ACC_W-1]` is always 0.

## Structure

- Shared package `dcim_pkg`: `DCIM_PP_W`, `DCIM_NUM_ROWS`, `DCIM_IN_BITS`, the derived `SUM_W`/`ACC_W` functions, and the FSM state enum `acc_state_t`.
- One sub-module, `dcim_adder_tree`: a parameterised, purely combinational reduction of `NUM_ROWS` unsigned `PP_W` operands to `SUM_W`.
- Accumulator, counter and FSM live in the top module.

## Test plan

- **All ones, unsigned:** all rows 12'hFFF on all 8 planes, macro off -> sum 32760 per plane; `res_data` = 8,353,800 one cycle after the 8th transfer.
- **All ones, signed:** same stimulus with `DCIM_SIGNED_ACT_EN` -> `res_data` = -32760 (24'hFF8008).
- **LSB only with bubbles:** row0 = 1 on the final plane only, all else 0, with `pp_valid` gaps of 0–3 cycles -> `res_data` = 1; `cnt` never advances on a bubble.
- **Backpressure:** `res_ready` low for 5 cycles in DONE -> `res_valid`=1 and `res_data` held constant, `pp_ready`=0 throughout; IDLE the cycle after `res_ready` rises.
- **Reset mid-operation:** `rst` pulsed after 3 planes -> next cycle shows IDLE, `busy`=0, `res_valid`=0; a following full operation gives the correct result.
- **Back-to-back:** two operations with continuous `pp_valid` and `res_ready`=1 -> results spaced 9 cycles apart, both correct.

Source files
------------

// File: rtl/dcim_pkg.sv
// Shared constants, derived-width helpers and the accumulator FSM state type
// for the DCIM column shift-accumulate path.
package dcim_pkg;

    localparam int DCIM_PP_W     = 12;
    localparam int DCIM_NUM_ROWS = 8;
    localparam int DCIM_IN_BITS  = 8;

    function automatic int sum_w(input int pp_w, input int num_rows);
        return pp_w + $clog2(num_rows);
    endfunction

    // One guard bit above the fully shifted sum keeps the signed mode exact.
    function automatic int acc_w(input int sum_w_v, input int in_bits);
        return sum_w_v + in_bits + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/dcim_shift_accumulator_if.sv
// Partial-product input and result output handshake bundle of the
// shift-accumulate stage; the slave modport is the accumulator side.
interface dcim_shift_accumulator_if
    import dcim_pkg::*;
#(
    parameter int NUM_ROWS = DCIM_NUM_ROWS,
    parameter int PP_W     = DCIM_PP_W,
    parameter int ACC_W    = acc_w(sum_w(DCIM_PP_W, DCIM_NUM_ROWS), DCIM_IN_BITS)
);

    logic                     pp_valid;
    logic                     pp_ready;
    logic [NUM_ROWS*PP_W-1:0] pp_data;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic                     busy;

    modport master (
        output pp_valid, pp_data, res_ready,
        input  pp_ready, res_valid, res_data, busy
    );

    modport slave (
        input  pp_valid, pp_data, res_ready,
        output pp_ready, res_valid, res_data, busy
    );

endinterface

// File: rtl/dcim_adder_tree.sv
// Combinational pairwise reduction of NUM_ROWS unsigned PP_W operands into a
// SUM_W-bit sum that cannot overflow.
module dcim_adder_tree
    import dcim_pkg::*;
#(
    parameter int NUM_ROWS = DCIM_NUM_ROWS,
    parameter int PP_W     = DCIM_PP_W,
    parameter int SUM_W    = sum_w(PP_W, NUM_ROWS)
) (
    input  logic [NUM_ROWS*PP_W-1:0] operands_i,
    output logic [SUM_W-1:0]         sum_o
);

    logic [SUM_W-1:0] part_s [NUM_ROWS];

    // Each pass halves the live operand count; slot 0 ends up holding the root.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            part_s[r] = {{(SUM_W-PP_W){1'b0}}, operands_i[r*PP_W +: PP_W]};
        end
        for (int w = NUM_ROWS / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                part_s[i] = part_s[2*i] + part_s[2*i+1];
            end
        end
    end

    assign sum_o = part_s[0];

endmodule

// File: rtl/dcim_shift_accumulator.sv
// Bit-serial shift-accumulate stage: folds IN_BITS bit-plane sums MSB first
// and hands the column dot product out over a valid/ready handshake.
// Optional macro DCIM_SIGNED_ACT_EN: two's-complement activations (MSB plane negated).
module dcim_shift_accumulator
    import dcim_pkg::*;
#(
    parameter int NUM_ROWS = DCIM_NUM_ROWS,
    parameter int PP_W     = DCIM_PP_W,
    parameter int IN_BITS  = DCIM_IN_BITS,
    parameter int SUM_W    = sum_w(PP_W, NUM_ROWS),
    parameter int ACC_W    = acc_w(SUM_W, IN_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    dcim_shift_accumulator_if.slave  bus
);

    localparam int CNT_W = $clog2(IN_BITS + 1);

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [SUM_W-1:0] sum_s;
    logic [ACC_W-1:0] sum_ext_s;
    logic [ACC_W-1:0] first_plane_s;
    logic             pp_ready_s;
    logic             res_valid_s;
    logic             busy_s;
    logic             pp_xfer_s;
    logic             res_xfer_s;
    logic             last_plane_s;

    dcim_adder_tree #(
        .NUM_ROWS (NUM_ROWS),
        .PP_W     (PP_W),
        .SUM_W    (SUM_W)
    ) u_adder_tree (
        .operands_i (bus.pp_data),
        .sum_o      (sum_s)
    );

    assign sum_ext_s = {{(ACC_W-SUM_W){1'b0}}, sum_s};
`ifdef DCIM_SIGNED_ACT_EN
    assign first_plane_s = {ACC_W{1'b0}} - sum_ext_s;
`else
    assign first_plane_s = sum_ext_s;
`endif

    assign pp_xfer_s    = bus.pp_valid && pp_ready_s;
    assign res_xfer_s   = res_valid_s && bus.res_ready;
    assign last_plane_s = (cnt_q == CNT_W'(IN_BITS - 1));

    // State, accumulator and plane counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pp_xfer_s) state_d = ST_ACCUM;
                else           state_d = ST_IDLE;
            end
            ST_ACCUM: begin
                if (pp_xfer_s && last_plane_s) state_d = ST_DONE;
                else                           state_d = ST_ACCUM;
            end
            ST_DONE: begin
                if (res_xfer_s) state_d = ST_IDLE;
                else            state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath update; bubbles leave acc and cnt untouched.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pp_xfer_s) begin
                    acc_d = first_plane_s;
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            ST_ACCUM: begin
                if (pp_xfer_s) begin
                    acc_d = (acc_q << 1) + sum_ext_s;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_DONE: begin
                if (res_xfer_s) cnt_d = {CNT_W{1'b0}};
                else            cnt_d = cnt_q;
            end
            default: begin
                acc_d = {ACC_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Handshake outputs are pure state decodes, so res_ready never reaches pp_ready.
    always_comb begin
        pp_ready_s  = 1'b0;
        res_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pp_ready_s = 1'b1;
            end
            ST_ACCUM: begin
                pp_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                res_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                pp_ready_s = 1'b0;
            end
        endcase
    end

    assign bus.pp_ready  = pp_ready_s;
    assign bus.res_valid = res_valid_s;
    assign bus.busy      = busy_s;
    assign bus.res_data  = acc_q;

endmodule

// File: tb/tb_dcim_shift_accumulator.sv
// Self-checking bench for dcim_shift_accumulator: directed vector table, random
// operations against a weighted-sum model, and multi-cycle corner sequences.
module tb_dcim_shift_accumulator;
    import dcim_pkg::*;

    localparam int NR = 8;
    localparam int PW = 12;
    localparam int IB = 8;
    localparam int AW = 24;

`ifdef DCIM_SIGNED_ACT_EN
    localparam logic [AW-1:0] EXP_ONES = 24'hFF8008;
    localparam logic [AW-1:0] EXP_MSB  = 24'hFFFF80;
    localparam logic [AW-1:0] EXP_ROW0 = 24'hFFFFFF;
`else
    localparam logic [AW-1:0] EXP_ONES = 24'd8353800;
    localparam logic [AW-1:0] EXP_MSB  = 24'd128;
    localparam logic [AW-1:0] EXP_ROW0 = 24'd255;
`endif

    typedef logic [IB-1:0][NR*PW-1:0] planes_t;
    typedef struct {
        string          name;
        planes_t        planes;
        int             max_gap;
        logic [AW-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dcim_shift_accumulator_if #(.NUM_ROWS(NR), .PP_W(PW), .ACC_W(AW)) bus ();

    dcim_shift_accumulator #(.NUM_ROWS(NR), .PP_W(PW), .IN_BITS(IB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*PW-1:0] rand_plane();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Dot product as a weighted sum of plane sums; plane 0 carries weight 2^(IB-1).
    function automatic logic [AW-1:0] model(input planes_t p);
        longint total = 0;
        for (int k = 0; k < IB; k++) begin
            longint s = 0;
            longint w = longint'(1) << (IB - 1 - k);
            for (int r = 0; r < NR; r++) s += longint'(p[k][r*PW +: PW]);
`ifdef DCIM_SIGNED_ACT_EN
            if (k == 0) total -= s * w;
            else        total += s * w;
`else
            total += s * w;
`endif
        end
        return total[AW-1:0];
    endfunction

    task automatic send_op(input planes_t p, input int max_gap,
                           output logic [AW-1:0] res, output logic got_valid);
        for (int k = 0; k < IB; k++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.pp_valid = 1'b0;
                bus.pp_data  = rand_plane();
                tick();
            end
            bus.pp_valid = 1'b1;
            bus.pp_data  = p[k];
            tick();
        end
        bus.pp_valid = 1'b0;
        got_valid    = bus.res_valid;
        res          = bus.res_data;
    endtask

    task automatic accept_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    vec_t          vecs [5];
    planes_t       p;
    planes_t       pb;
    logic [AW-1:0] res;
    logic          gv;

    initial begin
        rst           = 1'b1;
        bus.pp_valid  = 1'b0;
        bus.pp_data   = '0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_pp_ready", bus.pp_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_busy", bus.busy, 0);

        vecs[0].name = "all_ones";  vecs[0].planes = '1; vecs[0].max_gap = 0; vecs[0].exp = EXP_ONES;
        vecs[1].name = "zeros";     vecs[1].planes = '0; vecs[1].max_gap = 1; vecs[1].exp = '0;
        vecs[2].name = "lsb_only";  vecs[2].planes = '0; vecs[2].max_gap = 3; vecs[2].exp = 24'd1;
        vecs[2].planes[IB-1] = 96'h1;
        vecs[3].name = "msb_only";  vecs[3].planes = '0; vecs[3].max_gap = 2; vecs[3].exp = EXP_MSB;
        vecs[3].planes[0] = 96'h1;
        vecs[4].name = "row0_all";  vecs[4].max_gap = 0; vecs[4].exp = EXP_ROW0;
        for (int k = 0; k < IB; k++) vecs[4].planes[k] = 96'h1;

        for (int i = 0; i < 5; i++) begin
            send_op(vecs[i].planes, vecs[i].max_gap, res, gv);
            check({vecs[i].name, "_valid"}, gv, 1);
            check({vecs[i].name, "_data"}, res, vecs[i].exp);
            check({vecs[i].name, "_pp_ready_done"}, bus.pp_ready, 0);
            accept_result();
            check({vecs[i].name, "_idle_busy"}, bus.busy, 0);
        end

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < IB; k++) p[k] = rand_plane();
            if (n % 4 == 1) p[0] = '0;
            send_op(p, 2, res, gv);
            check("rand_valid", gv, 1);
            check("rand_data", res, model(p));
`ifndef DCIM_SIGNED_ACT_EN
            check("rand_msb_zero", res[AW-1], 0);
`endif
            accept_result();
        end

        // Bubbles of 0..3 cycles before each plane must not move the plane counter.
        p = '0;
        p[IB-1] = 96'h1;
        for (int k = 0; k < IB; k++) begin
            for (int g = 0; g < (k % 4); g++) begin
                bus.pp_valid = 1'b0;
                bus.pp_data  = rand_plane();
                tick();
                check("bubble_cnt", dut.cnt_q, k);
                check("bubble_no_valid", bus.res_valid, 0);
            end
            bus.pp_valid = 1'b1;
            bus.pp_data  = p[k];
            tick();
        end
        bus.pp_valid = 1'b0;
        check("bubble_valid", bus.res_valid, 1);
        check("bubble_data", bus.res_data, 1);
        accept_result();

        // Backpressure in DONE with a plane offered that must be ignored.
        for (int k = 0; k < IB; k++) p[k] = rand_plane();
        send_op(p, 0, res, gv);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", bus.res_valid, 1);
            check("bp_data", bus.res_data, model(p));
            check("bp_pp_ready", bus.pp_ready, 0);
            bus.pp_valid = 1'b1;
            bus.pp_data  = rand_plane();
            tick();
        end
        bus.pp_valid = 1'b0;
        accept_result();
        check("bp_idle_busy", bus.busy, 0);
        check("bp_idle_valid", bus.res_valid, 0);
        check("bp_idle_pp_ready", bus.pp_ready, 1);

        // Reset after three planes discards the partial result.
        for (int k = 0; k < 3; k++) begin
            bus.pp_valid = 1'b1;
            bus.pp_data  = rand_plane();
            tick();
        end
        check("midrst_busy_before", bus.busy, 1);
        bus.pp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.res_valid, 0);
        check("midrst_pp_ready", bus.pp_ready, 1);
        check("midrst_data", bus.res_data, 0);
        check("midrst_cnt", dut.cnt_q, 0);
        for (int k = 0; k < IB; k++) p[k] = rand_plane();
        send_op(p, 1, res, gv);
        check("midrst_after_valid", gv, 1);
        check("midrst_after_data", res, model(p));
        accept_result();

        // Back-to-back operations with pp_valid and res_ready held high.
        begin
            int            idx  = 0;
            int            nres = 0;
            int            cyc  = 0;
            int            t_res [2];
            logic [AW-1:0] d_res [2];
            for (int k = 0; k < IB; k++) begin
                p[k]  = rand_plane();
                pb[k] = rand_plane();
            end
            bus.res_ready = 1'b1;
            while (nres < 2 && cyc < 40) begin
                logic xfer;
                logic rv;
                logic [AW-1:0] rd;
                if (idx < IB) begin
                    bus.pp_valid = 1'b1;
                    bus.pp_data  = p[idx];
                end else if (idx < 2*IB) begin
                    bus.pp_valid = 1'b1;
                    bus.pp_data  = pb[idx-IB];
                end else begin
                    bus.pp_valid = 1'b0;
                end
                xfer = bus.pp_valid && bus.pp_ready;
                rv   = bus.res_valid;
                rd   = bus.res_data;
                tick();
                cyc++;
                if (xfer) idx++;
                if (rv) begin
                    t_res[nres] = cyc;
                    d_res[nres] = rd;
                    nres++;
                end
            end
            bus.res_ready = 1'b0;
            bus.pp_valid  = 1'b0;
            check("b2b_count", nres, 2);
            if (nres == 2) begin
                check("b2b_first", d_res[0], model(p));
                check("b2b_second", d_res[1], model(pb));
                check("b2b_spacing", t_res[1] - t_res[0], IB + 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
